lcd_rom_streamer: RTL and testbench
===================================

// Module: lcd_rom_streamer
// PURPOSE
//  Frame-buffer read engine directly downstream-facing of the 16-bit pixel block ROM:
//  drives its address port, absorbs its fixed 1-cycle registered read latency, and
//  streams a rectangular window of RGB565 pixels to the LCD write interface over
//  valid/ready. Hides the ROM's lack of a read enable via a credit-limited output FIFO.
// PARAMETERS
//  ADDR_WIDTH  17  ROM word-address width; address arithmetic wraps modulo 2**ADDR_WIDTH
//  DATA_WIDTH  16  pixel width (RGB565)
//  DIM_WIDTH   9   width/height field width (max 511, covers 240x320)
//  FIFO_DEPTH  4   output FIFO entries; power of 2, >=3 for 1 pixel/cycle sustained
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rst          in   1           synchronous active-high reset
//  start_i      in   1           frame request; sampled only in IDLE
//  base_addr_i  in   ADDR_WIDTH  first pixel word address; latched on accepted start
//  width_i      in   DIM_WIDTH   pixels per row; latched on accepted start
//  height_i     in   DIM_WIDTH   rows; latched on accepted start
//  busy_o       out  1           high from accepted start until done_o
//  done_o       out  1           1-cycle pulse: frame complete
//  rom_addr_o   out  ADDR_WIDTH  to ROM addr_i (registered)
//  rom_data_i   in   DATA_WIDTH  from ROM data_o; = mem[rom_addr_o of previous cycle]
//  pix_data_o   out  DATA_WIDTH  pixel to LCD writer
//  pix_valid_o  out  1           pixel valid
//  pix_ready_i  in   1           LCD writer accepts; transfer = valid & ready
//  pix_eol_o    out  1           qualifies pix_data_o: last pixel of a row
//  pix_last_o   out  1           qualifies pix_data_o: last pixel of frame
// BEHAVIOUR
//  - Reset: all outputs 0, rom_addr_o=0, FIFO empty, in-flight=0, state IDLE. Reset
//    mid-frame aborts immediately: FIFO flushed, no done_o, ROM data in flight discarded.
//  - States: IDLE -start_i-> RUN (issue addresses) -last addr issued-> DRAIN
//    -last pixel transferred-> DONE (1 cycle, done_o=1) -> IDLE.
//  - start_i with width_i==0 or height_i==0: IDLE->DONE; no addresses, no pix_valid_o.
//  - start_i while not IDLE: ignored; latched config unchanged.
//  - Address: row-major, contiguous, addr=base+row*width+col, generated incrementally
//    (no multiplier); wraps 2**ADDR_WIDTH-1 -> 0.
//  - Issue rule: one address per cycle while fifo_count + inflight < FIFO_DEPTH;
//    inflight = issued addresses whose ROM data is not yet written (0..2). When not
//    issuing, rom_addr_o holds value; corresponding rom_data_i is not written.
//  - Pipeline: start_i high cycle 0 -> rom_addr_o=base cycle 1 -> rom_data_i valid
//    cycle 2, written to FIFO edge ending cycle 2 -> pix_valid_o=1 cycle 3.
//  - FIFO write of issued word and pop by handshake in the same cycle both take effect;
//    count unchanged. No overflow possible by issue rule; overflow is a design bug.
//  - pix_valid_o stays high and pix_data_o/eol/last stable until pix_ready_i.
//  - pix_eol_o/pix_last_o tagged at issue time, stored alongside data in the FIFO.
//  - done_o asserts the cycle after the pix_last_o transfer; busy_o falls with it.
//  - With pix_ready_i held high: one pixel per cycle after initial 3-cycle latency.
// TESTING
//  1 Reset: assert rst 2 cycles mid-RUN -> all outputs 0 next cycle, no done_o, then
//    new start delivers fresh frame from its own base.
//  2 base=0x00010, width=4, height=2, ready=1, ROM mem[i]=i -> addrs 0x10..0x17,
//    pixels 0x0010..0x0017 on consecutive cycles from cycle 3, eol on 0x13 and 0x17,
//    last on 0x17, done_o 1 cycle later.
//  3 Same frame, pix_ready_i random 30% -> exactly 8 transfers, in order, no
//    duplicates, data stable while valid&!ready.
//  4 Wrap: base=0x1FFFE, width=4, height=1 -> addrs 0x1FFFE,0x1FFFF,0x00000,0x00001.
//  5 width=0, height=5 -> done_o pulse cycle 1, pix_valid_o never high.
//  6 start_i pulsed during RUN with different base -> ignored; frame completes with
//    original config; 240x320 frame with ready=1 gives 76800 transfers, one per cycle.

Source files
------------

// File: rtl/lcd_rom_streamer_if.sv
// Pixel stream from the ROM streamer to the LCD writer: valid/ready handshake
// with per-pixel end-of-row and end-of-frame qualifiers.
interface lcd_rom_streamer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  eol;
  logic                  last;

  modport master (output data, output valid, output eol, output last, input ready);
  modport slave  (input data, input valid, input eol, input last, output ready);
endinterface

// File: rtl/lcd_rom_streamer.sv
// Streams a rectangular window of pixels out of a 1-cycle-latency ROM that has no
// read enable; a small output FIFO plus an issue credit check absorb back-pressure.
module lcd_rom_streamer #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [DIM_WIDTH-1:0]  width_i,
  input  logic [DIM_WIDTH-1:0]  height_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  lcd_rom_streamer_if.master    pix
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [DIM_WIDTH-1:0]  w_q, h_q, col_q, row_q;

  logic                  vld_p0, vld_p1;
  logic                  eol_p0, last_p0, eol_p1, last_p1;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_eol  [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        fifo_cnt;

  logic                  start_ok, dims_zero, issue, push, pop;
  logic [DIM_WIDTH-1:0]  cur_col, cur_row, cur_w, cur_h;
  logic                  cur_eol, cur_last;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [PTR_W+1:0]      occupancy;

  // In IDLE the first pixel is issued straight from the start inputs so its
  // address is on the ROM one cycle after start.
  always_comb begin
    start_ok  = (state == S_IDLE) && start_i;
    dims_zero = (width_i == '0) || (height_i == '0);
    if (state == S_IDLE) begin
      cur_col   = '0;
      cur_row   = '0;
      cur_w     = width_i;
      cur_h     = height_i;
      next_addr = base_addr_i;
    end else begin
      cur_col   = col_q;
      cur_row   = row_q;
      cur_w     = w_q;
      cur_h     = h_q;
      next_addr = rom_addr_o + ADDR_WIDTH'(1);
    end
    cur_eol   = (cur_col == cur_w - DIM_WIDTH'(1));
    cur_last  = cur_eol && (cur_row == cur_h - DIM_WIDTH'(1));
    occupancy = {1'b0, fifo_cnt} + (PTR_W+2)'(vld_p0) + (PTR_W+2)'(vld_p1);
    issue     = (start_ok && !dims_zero) ||
                ((state == S_RUN) && (occupancy < (PTR_W+2)'(FIFO_DEPTH)));
    push      = vld_p1;
    pop       = pix.valid && pix.ready;
  end

  assign pix.valid = (fifo_cnt != '0);
  assign pix.data  = pix.valid ? fifo_data[rd_ptr] : '0;
  assign pix.eol   = pix.valid && fifo_eol[rd_ptr];
  assign pix.last  = pix.valid && fifo_last[rd_ptr];
  assign busy_o    = (state == S_RUN) || (state == S_DRAIN);
  assign done_o    = (state == S_DONE);

  // Control: FSM, address generator, in-flight tracking, FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rom_addr_o <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      vld_p0 <= issue;
      vld_p1 <= vld_p0;
      if (issue) begin
        rom_addr_o <= next_addr;
        col_q      <= cur_eol ? '0 : cur_col + DIM_WIDTH'(1);
        row_q      <= cur_eol ? cur_row + DIM_WIDTH'(1) : cur_row;
      end
      case (state)
        S_IDLE: if (start_i) begin
          w_q   <= width_i;
          h_q   <= height_i;
          state <= dims_zero ? S_DONE : (cur_last ? S_DRAIN : S_RUN);
        end
        S_RUN:   if (issue && cur_last) state <= S_DRAIN;
        S_DRAIN: if (pop && pix.last) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // ---- p0: address on ROM / p1: ROM data valid, written into the FIFO ----
  always_ff @(posedge clk) begin
    eol_p0  <= cur_eol;
    last_p0 <= cur_last;
    eol_p1  <= eol_p0;
    last_p1 <= last_p0;
    if (push) begin
      fifo_data[wr_ptr] <= rom_data_i;
      fifo_eol[wr_ptr]  <= eol_p1;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

endmodule

// File: tb/tb_lcd_rom_streamer.sv
// Self-checking bench: ROM model, frame-level scoreboard, directed and random frames.
module tb_lcd_rom_streamer;
  localparam int AW  = 17;
  localparam int DW  = 16;
  localparam int DMW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, busy, done;
  logic [AW-1:0]  base, rom_addr;
  logic [DMW-1:0] wid, hgt;
  logic [DW-1:0]  rom_data;

  lcd_rom_streamer_if #(.DATA_WIDTH(DW)) pix_if ();

  lcd_rom_streamer dut (
    .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base),
    .width_i(wid), .height_i(hgt), .busy_o(busy), .done_o(done),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data), .pix(pix_if)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return a[15:0] ^ {a[16], 15'd0};
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  typedef struct packed {logic [DW-1:0] d; logic eol; logic last;} pix_t;
  pix_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [AW-1:0] b, input int w, input int h);
    pix_t p;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        p.d    = rom_word(b + AW'(r * w + c));
        p.eol  = (c == w - 1);
        p.last = (c == w - 1) && (r == h - 1);
        exp_q.push_back(p);
      end
  endtask

  int ready_pct = 100;
  always @(posedge clk) begin
    #1;
    pix_if.ready = ($urandom_range(0, 99) < ready_pct);
  end

  int cyc = 0, xfers = 0, first_x = 0, last_x = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_word;
  always @(negedge clk) begin
    pix_t e;
    logic [31:0] word;
    cyc++;
    word = 32'({pix_if.data, pix_if.eol, pix_if.last});
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(pix_if.valid), 32'd1);
        check("hold_data", word, prev_word);
      end
      if (pix_if.valid && pix_if.ready) begin
        if (exp_q.size() == 0) check("unexpected_xfer", word, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("pixel", word, 32'(e));
        end
        if (xfers == 0) first_x = cyc;
        last_x = cyc;
        xfers++;
      end
      prev_stall = pix_if.valid && !pix_if.ready;
      prev_word  = word;
    end
  end

  task automatic start_frame(input logic [AW-1:0] b, input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1; base = b; wid = DMW'(w); hgt = DMW'(h);
    push_frame(b, w, h);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("frame_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] wrap_addr [4];
    logic [AW-1:0] rb;
    int rw, rh;
    rst = 1'b1; start = 1'b0; base = '0; wid = '0; hgt = '0;
    pix_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(pix_if.valid), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_data", 32'({pix_if.data, pix_if.eol, pix_if.last}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed 4x2 frame, exact cycle timing with ready held high.
    ready_pct = 100; xfers = 0;
    start_frame(17'h00010, 4, 2);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("t2_addr_c%0d", k), 32'(rom_addr), (k <= 8) ? 32'h10 + 32'(k - 1) : 32'h17);
      check($sformatf("t2_valid_c%0d", k), 32'(pix_if.valid), 32'(k >= 3 && k <= 10));
      check($sformatf("t2_done_c%0d", k), 32'(done), 32'(k == 11));
      check($sformatf("t2_busy_c%0d", k), 32'(busy), 32'(k <= 10));
    end
    check("t2_xfers", 32'(xfers), 32'd8);
    check("t2_span", 32'(last_x - first_x), 32'd7);

    // Same frame under random back-pressure.
    ready_pct = 70; xfers = 0;
    start_frame(17'h00010, 4, 2);
    wait_done(200);
    check("t3_xfers", 32'(xfers), 32'd8);

    // Address wrap.
    ready_pct = 100; xfers = 0;
    wrap_addr = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    start_frame(17'h1FFFE, 4, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t4_addr%0d", k), 32'(rom_addr), 32'(wrap_addr[k]));
    end
    wait_done(50);
    check("t4_xfers", 32'(xfers), 32'd4);

    // Zero-sized frames finish immediately with no pixels.
    start_frame(17'h00123, 0, 5);
    @(negedge clk);
    check("t5_done_w0", 32'(done), 1);
    check("t5_busy_w0", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_done_after", 32'(done), 0);
      check("t5_no_valid", 32'(pix_if.valid), 0);
    end
    start_frame(17'h00010, 7, 0);
    @(negedge clk);
    check("t5_done_h0", 32'(done), 1);
    check("t5_no_valid_h0", 32'(pix_if.valid), 0);

    // start_i during RUN is ignored.
    ready_pct = 60; xfers = 0;
    start_frame(17'h00100, 8, 3);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; base = 17'h05000; wid = 9'd2; hgt = 9'd2;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400);
    check("t6_xfers", 32'(xfers), 32'd24);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t6_idle_valid", 32'(pix_if.valid), 0);
      check("t6_idle_busy", 32'(busy), 0);
    end

    // Reset mid-frame aborts; next start gives a fresh frame.
    ready_pct = 60; xfers = 0;
    start_frame(17'h02000, 20, 10);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t1_busy", 32'(busy), 0);
    check("t1_done", 32'(done), 0);
    check("t1_valid", 32'(pix_if.valid), 0);
    check("t1_addr", 32'(rom_addr), 0);
    check("t1_pix", 32'({pix_if.data, pix_if.eol, pix_if.last}), 0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t1_no_done", 32'(done), 0);
      check("t1_no_valid", 32'(pix_if.valid), 0);
    end
    ready_pct = 100; xfers = 0;
    start_frame(17'h03000, 5, 3);
    wait_done(100);
    check("t1_fresh_xfers", 32'(xfers), 32'd15);

    // Random frames with random base and back-pressure.
    for (int i = 0; i < 10; i++) begin
      rb = AW'($urandom);
      rw = $urandom_range(1, 12);
      rh = $urandom_range(1, 6);
      ready_pct = (i % 3 == 0) ? 100 : ((i % 3 == 1) ? 70 : 30);
      xfers = 0;
      start_frame(rb, rw, rh);
      wait_done(rw * rh * 30 + 50);
      check($sformatf("rand%0d_xfers", i), 32'(xfers), 32'(rw * rh));
    end

    // Full 240x320 frame at one pixel per cycle.
    ready_pct = 100; xfers = 0;
    start_frame(17'h00400, 240, 320);
    wait_done(80000);
    check("big_xfers", 32'(xfers), 32'd76800);
    check("big_span", 32'(last_x - first_x), 32'd76799);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
